// File: rtl/sub_pkg.sv
// Shared types and helpers for the multi-cycle subtractor.
// Holds the FSM state type and the chunk-count function.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int nchunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit subtract slice with borrow in/out.
// The top level reuses one instance for every slice.
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo
);

    // Extra top bit of the widened difference is the borrow-out
    assign {bo, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bi};

endmodule

// File: rtl/sub_32_seq.sv
// Multi-cycle subtractor: in1 - in2 - bin, one CHUNK slice per cycle.
// Valid/ready on both sides; one transaction in flight at a time.
module sub_32_seq
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = nchunks(WIDTH, CHUNK);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("sub_32_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             bor;
    logic             bout_q;
    logic             ovf_q;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    logic [CHUNK-1:0] sd;
    logic             sbo;
    logic             accept;
    logic             last;
    int               base;

    assign base = int'(idx) * CHUNK;
    assign sa   = a_q[base +: CHUNK];
    assign sb   = b_q[base +: CHUNK];
    assign last = (idx == LAST);

    sub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a (sa),
        .b (sb),
        .bi(bor),
        .d (sd),
        .bo(sbo)
    );

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand latch, per-slice result write and borrow chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            bor    <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q    <= in1;
            b_q    <= in2;
            bor    <= bin;
            diff_q <= '0;
            idx    <= '0;
        end else if (state == BUSY) begin
            diff_q[base +: CHUNK] <= sd;
            bor <= sbo;
            idx <= idx + IW'(1);
            if (last) begin
                bout_q <= sbo;
                ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                        & (sd[CHUNK-1] ^ a_q[WIDTH-1]);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub_32_seq.sv
// Directed self-checking bench for sub_32_seq (default WIDTH/CHUNK).
// Drives and samples 1 time unit after each rising edge.
module tb_sub_32_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int out_cnt = 0;

    sub_32_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready)   acc_cnt <= acc_cnt + 1;
        if (out_valid && out_ready) out_cnt <= out_cnt + 1;
    end

    task automatic run_txn(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic         bi,
        input  int           hold,
        output logic [W-1:0] d,
        output logic         bo,
        output logic         ov,
        output int           lat,
        output bit           ok
    );
        int n;
        ok = 1'b1; lat = 0; d = '0; bo = 1'b0; ov = 1'b0; n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin ok = 1'b0; return; end
        in1 = a; in2 = b; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; bin = 1'($urandom);
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin ok = 1'b0; return; end
        repeat (hold) begin @(posedge clk); #1; end
        d = diff; bo = bout; ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks += 5;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (diff !== '0) begin errors++;
            $display("FAIL reset_diff got %h want 0", diff); end
        if (bout !== 1'b0) begin errors++;
            $display("FAIL reset_bout got %b want 0", bout); end
        if (ovf !== 1'b0) begin errors++;
            $display("FAIL reset_ovf got %b want 0", ovf); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] d; logic bo, ov; int lat; bit ok;
        run_txn(32'd5, 32'd3, 1'b0, 0, d, bo, ov, lat, ok);
        checks += 5;
        if (ok !== 1'b1) begin errors++;
            $display("FAIL basic_timeout got %b want 1", ok); end
        if (d !== 32'h0000_0002) begin errors++;
            $display("FAIL basic_diff got %h want 00000002", d); end
        if (bo !== 1'b0) begin errors++;
            $display("FAIL basic_bout got %b want 0", bo); end
        if (ov !== 1'b0) begin errors++;
            $display("FAIL basic_ovf got %b want 0", ov); end
        if (lat != 4) begin errors++;
            $display("FAIL basic_latency got %0d want 4", lat); end
    endtask

    task automatic test_borrow();
        logic [W-1:0] d; logic bo, ov; int lat; bit ok;
        run_txn(32'd0, 32'd1, 1'b0, 1, d, bo, ov, lat, ok);
        checks += 3;
        if (d !== 32'hFFFF_FFFF || !ok) begin errors++;
            $display("FAIL borrow0_diff got %h want ffffffff", d); end
        if (bo !== 1'b1) begin errors++;
            $display("FAIL borrow0_bout got %b want 1", bo); end
        if (ov !== 1'b0) begin errors++;
            $display("FAIL borrow0_ovf got %b want 0", ov); end
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0,
                d, bo, ov, lat, ok);
        checks += 3;
        if (d !== 32'hFFFF_FFFF || !ok) begin errors++;
            $display("FAIL borrow1_diff got %h want ffffffff", d); end
        if (bo !== 1'b1) begin errors++;
            $display("FAIL borrow1_bout got %b want 1", bo); end
        if (ov !== 1'b0) begin errors++;
            $display("FAIL borrow1_ovf got %b want 0", ov); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] d; logic bo, ov; int lat; bit ok;
        run_txn(32'h8000_0000, 32'd1, 1'b0, 0, d, bo, ov, lat, ok);
        checks += 3;
        if (d !== 32'h7FFF_FFFF || !ok) begin errors++;
            $display("FAIL ovf0_diff got %h want 7fffffff", d); end
        if (bo !== 1'b0) begin errors++;
            $display("FAIL ovf0_bout got %b want 0", bo); end
        if (ov !== 1'b1) begin errors++;
            $display("FAIL ovf0_ovf got %b want 1", ov); end
        run_txn(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2,
                d, bo, ov, lat, ok);
        checks += 3;
        if (d !== 32'h8000_0000 || !ok) begin errors++;
            $display("FAIL ovf1_diff got %h want 80000000", d); end
        if (bo !== 1'b1) begin errors++;
            $display("FAIL ovf1_bout got %b want 1", bo); end
        if (ov !== 1'b1) begin errors++;
            $display("FAIL ovf1_ovf got %b want 1", ov); end
    endtask

    task automatic test_backpressure();
        int n;
        in1 = 32'h0000_1000; in2 = 32'h0000_0FFF; bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in1 = 32'h0000_0020; in2 = 32'h0000_0030; bin = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || diff !== 32'd1 ||
                bout !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h b=%b r=%b want 1 1 0 0",
                         i, out_valid, diff, bout, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release got v=%b r=%b want 0 1",
                     out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_second_accept got r=%b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid !== 1'b1 || diff !== 32'hFFFF_FFEF ||
            bout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_result got v=%b d=%h b=%b o=%b want 1 ffffffef 1 0",
                     out_valid, diff, bout, ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d; logic bo, ov; int lat; bit ok;
        int pulses;
        in1 = 32'h1234_5678; in2 = 32'h0000_0001; bin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got r=%b v=%b d=%h b=%b o=%b want 1 0 0 0 0",
                     in_ready, out_valid, diff, bout, ovf);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++;
            $display("FAIL rstmid_no_pulse got %0d want 0", pulses); end
        run_txn(32'h0000_0100, 32'h0000_0001, 1'b0, 0,
                d, bo, ov, lat, ok);
        checks++;
        if (!ok || d !== 32'h0000_00FF || bo !== 1'b0) begin errors++;
            $display("FAIL rstmid_next got d=%h b=%b want 000000ff 0", d, bo); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [3] = '{32'd10, 32'h0000_0100, 32'h1234_5678};
        logic [W-1:0] vb [3] = '{32'd3,  32'h0000_0001, 32'h1111_1111};
        logic         vi [3] = '{1'b0,   1'b0,          1'b1};
        logic [W-1:0] ex [3] = '{32'd7,  32'h0000_00FF, 32'h0123_4566};
        int t [3];
        int ai, oi;
        bit acc;
        ai = 0; oi = 0;
        in1 = va[0]; in2 = vb[0]; bin = vi[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && oi < 3; c++) begin
            acc = in_ready && in_valid;
            if (out_valid) begin
                checks++;
                if (diff !== ex[oi]) begin errors++;
                    $display("FAIL b2b_diff %0d got %h want %h",
                             oi, diff, ex[oi]); end
                oi++;
            end
            @(posedge clk); #1;
            if (acc) begin
                t[ai] = c; ai++;
                if (ai < 3) begin
                    in1 = va[ai]; in2 = vb[ai]; bin = vi[ai];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (oi != 3 || ai != 3) begin errors++;
            $display("FAIL b2b_count got acc=%0d out=%0d want 3 3", ai, oi); end
        else begin
            checks++;
            if (t[1] - t[0] != 6 || t[2] - t[1] != 6) begin errors++;
                $display("FAIL b2b_interval got %0d %0d want 6 6",
                         t[1] - t[0], t[2] - t[1]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, d, ed;
        logic bi, bo, ov, eb, eo;
        int lat, a0, o0;
        bit ok;
        a0 = acc_cnt; o0 = out_cnt;
        for (int i = 0; i < 200; i++) begin
            a = $urandom; b = $urandom; bi = 1'($urandom);
            if (i % 5 == 0) b = a;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            run_txn(a, b, bi, $urandom_range(0, 3), d, bo, ov, lat, ok);
            {eb, ed} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
            eo = (a[W-1] != b[W-1]) && (ed[W-1] != a[W-1]);
            checks++;
            if (!ok || d !== ed || bo !== eb || ov !== eo) begin
                errors++;
                $display("FAIL rand %0d a=%h b=%h bi=%b got %h %b %b want %h %b %b",
                         i, a, b, bi, d, bo, ov, ed, eb, eo);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (acc_cnt - a0 != out_cnt - o0) begin errors++;
            $display("FAIL rand_counts got acc=%0d out=%0d want equal",
                     acc_cnt - a0, out_cnt - o0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_32_seq.md
Name: sub_32_seq

Overview:
Multi-cycle 32-bit subtractor with borrow-in and borrow-out. It is the inverse-operation companion to the team's 32-bit adder. It computes in1 - in2 - bin one CHUNK-bit slice per cycle, which trades latency for a short carry chain. Operands arrive and results leave through valid/ready handshakes, so the block can sit between pipeline stages of the datapath.

Parameters:
WIDTH, 32, operand and result width
CHUNK, 8, bits subtracted per cycle; WIDTH must be an integer multiple of CHUNK (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in1  input  WIDTH  minuend
in2  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  (in1 - in2 - bin) mod 2^WIDTH
bout  output  1  borrow-out: 1 iff unsigned in1 < in2 + bin
ovf  output  1  signed overflow: in1[MSB] != in2[MSB] and diff[MSB] != in1[MSB]

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. The chunk index and the borrow register are cleared.
- Let N = WIDTH/CHUNK (default 4).
- IDLE state:
  - in_ready=1.
  - On in_valid && in_ready, latch in1, in2 and bin into the operand registers, clear diff, set the chunk index to 0, and go to BUSY.
- BUSY state:
  - in_ready=0.
  - Each cycle, compute slice k: {b_next, d_k} = in1[k] - in2[k] - b, where b starts as the latched bin.
  - Write d_k into diff[k*CHUNK +: CHUNK] and register b_next.
  - After slice N-1, set bout = final borrow and ovf per the formula above, then go to DONE.
- DONE state:
  - out_valid=1.
  - diff, bout and ovf are stable until the handshake completes.
  - On out_ready, out_valid falls next cycle and the block returns to IDLE.
- Latency: operands accepted at edge 0 give out_valid=1 after edge N (visible in cycle N+1). With out_ready held high, the block accepts a new transaction every N+2 cycles.
- No overlap: in_ready=0 in BUSY and DONE. An in_valid raised there is ignored; the source must hold it.
- Result registers are not cleared on return to IDLE. Their content is don't-care while out_valid=0.
- Input operands may change freely after acceptance; the result depends only on the latched values.
- Reset mid-operation: the transaction is abandoned, outputs go to reset values immediately, and no partial out_valid appears.
- Wrap-around: results are modulo 2^WIDTH. bout signals the wrap; no saturation.
- Equivalence: bout and diff must match a combinational {bout,diff} = {1'b0,in1} - {1'b0,in2} - bin for all inputs.

Decomposition:
- Package sub_pkg holds:
  - localparam WIDTH_DEFAULT=32;
  - the state enum {IDLE, BUSY, DONE} as a 2-bit type;
  - the function nchunks(WIDTH,CHUNK).
- Sub-module sub_chunk: purely combinational CHUNK-bit slice with ports a, b, bi and outputs d, bo. The top level instantiates it once and reuses it every cycle.
- The top level holds the FSM, operand, result and borrow registers, and the chunk counter.

Test Plan:
- in1=5, in2=3, bin=0 -> diff=0x00000002, bout=0, ovf=0; out_valid rises exactly N=4 cycles after the accept edge.
- in1=0, in2=1, bin=0 -> diff=0xFFFFFFFF, bout=1, ovf=0; in1=0xFFFFFFFF, in2=0xFFFFFFFF, bin=1 -> diff=0xFFFFFFFF, bout=1.
- in1=0x80000000, in2=1, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1; in1=0x7FFFFFFF, in2=0xFFFFFFFF -> diff=0x80000000, bout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, diff and bout are held; in_ready stays 0; a second in_valid is not accepted until one cycle after the out_ready handshake.
- Reset mid-operation: assert rst_n=0 asynchronously in BUSY at chunk 2 -> outputs go to 0 and in_ready=1 without waiting for a clock; no out_valid pulse after release; the next transaction is correct.
- 10k random transactions with random in_valid/out_ready gaps, CHUNK in {1,8,32} -> every result matches the combinational model; accept count equals output count.
